// File: rtl/relprime_pkg.sv
// Shared types and constants for the relprime coprocessor.
package relprime_pkg;

   // Outer FSM states
   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      GCD,
      DONE
   } state_t;

   localparam int unsigned DEF_WIDTH = 16;
   localparam int unsigned M_INIT    = 2;

endpackage

// File: rtl/relprime_if.sv
// Request/result bundle between the processor and the relprime engine.
// The cycles signal exists only when RELPRIME_CYCLE_COUNT_EN is defined.
interface relprime_if
   import relprime_pkg::*;
#(
   parameter int unsigned WIDTH = DEF_WIDTH
`ifdef RELPRIME_CYCLE_COUNT_EN
   , parameter int unsigned CNT_W = 32
`endif
);

   logic             start;
   logic [WIDTH-1:0] n_in;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] out;
   logic             error;
`ifdef RELPRIME_CYCLE_COUNT_EN
   logic [CNT_W-1:0] cycles;
`endif

`ifdef RELPRIME_CYCLE_COUNT_EN
   modport master (output start, n_in, input busy, done, out, error, cycles);
   modport slave  (input start, n_in, output busy, done, out, error, cycles);
`else
   modport master (output start, n_in, input busy, done, out, error);
   modport slave  (input start, n_in, output busy, done, out, error);
`endif

endinterface

// File: rtl/gcd_sub.sv
// Iterative subtract-based Euclid gcd. Loads a/b on go, then subtracts the
// smaller operand from the larger each cycle until they match.
module gcd_sub #(
   parameter int unsigned WIDTH = 16
) (
   input  logic             CLK,
   input  logic             reset,
   input  logic             go,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             done,
   output logic [WIDTH-1:0] result
);

   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic             active_q;
   logic             done_q;

   // Operand load, subtraction step and registered completion pulse
   always_ff @(posedge CLK) begin
      if (reset) begin
         a_q      <= '0;
         b_q      <= '0;
         active_q <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (go) begin
            a_q      <= a;
            b_q      <= b;
            active_q <= 1'b1;
         end else if (active_q) begin
            if (a_q == b_q) begin
               done_q   <= 1'b1;
               active_q <= 1'b0;
            end else if (a_q > b_q) begin
               a_q <= a_q - b_q;
            end else begin
               b_q <= b_q - a_q;
            end
         end
      end
   end

   assign done   = done_q;
   assign result = a_q;

endmodule

// File: rtl/relprime_engine.sv
// relprime coprocessor: returns the smallest m >= 2 with gcd(n, m) == 1.
// Optional cycle counter enabled by defining RELPRIME_CYCLE_COUNT_EN.
module relprime_engine
   import relprime_pkg::*;
#(
   parameter int unsigned WIDTH = DEF_WIDTH
`ifdef RELPRIME_CYCLE_COUNT_EN
   , parameter int unsigned CNT_W = 32
`endif
) (
   input logic       CLK,
   input logic       reset,
   relprime_if.slave bus
);

   state_t           state;
   logic [WIDTH-1:0] n_reg;
   logic [WIDTH-1:0] m;
   logic [WIDTH-1:0] out_q;
   logic             busy_q;
   logic             done_q;
   logic             error_q;

   logic             gcd_go;
   logic             gcd_done;
   logic [WIDTH-1:0] gcd_result;

`ifdef RELPRIME_CYCLE_COUNT_EN
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cycles_q;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == '1) ? v : v + 1'b1;
   endfunction
`endif

   assign gcd_go = (state == LOAD);

   gcd_sub #(
      .WIDTH (WIDTH)
   ) u_gcd (
      .CLK    (CLK),
      .reset  (reset),
      .go     (gcd_go),
      .a      (n_reg),
      .b      (m),
      .done   (gcd_done),
      .result (gcd_result)
   );

   // Outer FSM: steps candidate m until the gcd unit reports 1
   always_ff @(posedge CLK) begin
      if (reset) begin
         state    <= IDLE;
         n_reg    <= '0;
         m        <= '0;
         out_q    <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         error_q  <= 1'b0;
`ifdef RELPRIME_CYCLE_COUNT_EN
         cnt      <= '0;
         cycles_q <= '0;
`endif
      end else begin
         done_q <= 1'b0;
         unique case (state)
            IDLE: begin
               if (bus.start) begin
                  n_reg   <= bus.n_in;
                  m       <= WIDTH'(M_INIT);
                  error_q <= 1'b0;
                  if (bus.n_in == '0) begin
                     // No coprime exists for zero: report at once
                     out_q   <= '0;
                     error_q <= 1'b1;
                     done_q  <= 1'b1;
                     state   <= DONE;
`ifdef RELPRIME_CYCLE_COUNT_EN
                     cycles_q <= CNT_W'(2);
`endif
                  end else begin
                     busy_q <= 1'b1;
                     state  <= LOAD;
`ifdef RELPRIME_CYCLE_COUNT_EN
                     // Counts the accepting cycle plus the first busy cycle
                     cnt <= CNT_W'(2);
`endif
                  end
               end
            end
            LOAD: begin
               state <= GCD;
`ifdef RELPRIME_CYCLE_COUNT_EN
               cnt <= sat_inc(cnt);
`endif
            end
            GCD: begin
`ifdef RELPRIME_CYCLE_COUNT_EN
               cnt <= sat_inc(cnt);
`endif
               if (gcd_done) begin
                  if (gcd_result == WIDTH'(1)) begin
                     out_q  <= m;
                     busy_q <= 1'b0;
                     done_q <= 1'b1;
                     state  <= DONE;
`ifdef RELPRIME_CYCLE_COUNT_EN
                     // Include the upcoming DONE cycle
                     cycles_q <= sat_inc(cnt);
`endif
                  end else begin
                     m     <= m + 1'b1;
                     state <= LOAD;
                  end
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   // Candidate m starts at 2 and is bounded by n+1, so it must never wrap
   m_no_wrap: assert property (@(posedge CLK) disable iff (reset)
                               (state != IDLE) |-> (m != '0));

   assign bus.busy  = busy_q;
   assign bus.done  = done_q;
   assign bus.out   = out_q;
   assign bus.error = error_q;
`ifdef RELPRIME_CYCLE_COUNT_EN
   assign bus.cycles = cycles_q;
`endif

endmodule

// File: tb/tb_relprime_engine.sv
// Self-checking bench for relprime_engine: directed runs plus random operands
// checked every cycle against an arithmetic reference model.
module tb_relprime_engine;

   localparam int unsigned W   = 16;
   localparam int unsigned CW  = 32;
   localparam int          TMO = 40000;

   logic CLK;
   logic reset;

   int n_tests = 0;
   int n_fail  = 0;

`ifdef RELPRIME_CYCLE_COUNT_EN
   relprime_if #(.WIDTH(W), .CNT_W(CW)) bus ();
   relprime_engine #(.WIDTH(W), .CNT_W(CW)) dut (
      .CLK   (CLK),
      .reset (reset),
      .bus   (bus.slave)
   );
`else
   relprime_if #(.WIDTH(W)) bus ();
   relprime_engine #(.WIDTH(W)) dut (
      .CLK   (CLK),
      .reset (reset),
      .bus   (bus.slave)
   );
`endif

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   task automatic check(input string name, input longint act, input longint exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Reference model: plain Euclid with modulo and a linear search for m
   function automatic int model_gcd(input int a, input int b);
      int t;
      while (b != 0) begin
         t = a % b;
         a = b;
         b = t;
      end
      return a;
   endfunction

   function automatic int model_relprime(input int n);
      if (n == 0) return 0;
      for (int m = 2; m <= n + 1; m++) begin
         if (model_gcd(n, m) == 1) return m;
      end
      return -1;
   endfunction

   // Per-cycle compare process
   initial begin
      bit     active;
      bit     in_done;
      bit     rs;
      bit     st;
      int     nn;
      int     wc;
      int     exp_n;
      int     exp_out;
      int     exp_err;
      int     held_out;
      int     held_err;
      longint held_cyc;
      active = 0; in_done = 0; wc = 0; exp_n = 0; exp_out = 0; exp_err = 0;
      held_out = 0; held_err = 0; held_cyc = 0;
      forever begin
         @(posedge CLK);
         rs = reset;
         st = bus.start;
         nn = int'(bus.n_in);
         @(negedge CLK);
         if (rs) begin
            active = 0; in_done = 0;
            held_out = 0; held_err = 0; held_cyc = 0;
            check("rst_busy", longint'(bus.busy), 0);
            check("rst_done", longint'(bus.done), 0);
            check("rst_out", longint'(bus.out), 0);
            check("rst_error", longint'(bus.error), 0);
`ifdef RELPRIME_CYCLE_COUNT_EN
            check("rst_cycles", longint'(bus.cycles), 0);
`endif
         end else begin
            if (!active && !in_done && st) begin
               active  = 1;
               wc      = 0;
               exp_n   = nn;
               exp_out = model_relprime(nn);
               exp_err = (nn == 0) ? 1 : 0;
            end
            in_done = 0;
            if (active) begin
               wc++;
               if (bus.done) begin
                  check("done_out", longint'(bus.out), longint'(exp_out));
                  check("done_error", longint'(bus.error), longint'(exp_err));
                  check("done_busy", longint'(bus.busy), 0);
`ifdef RELPRIME_CYCLE_COUNT_EN
                  check("done_cycles", longint'(bus.cycles), longint'(wc + 1));
`endif
                  held_out = exp_out;
                  held_err = exp_err;
                  held_cyc = longint'(wc + 1);
                  active   = 0;
                  in_done  = 1;
               end else if (exp_n == 0) begin
                  check("zero_done_next", longint'(bus.done), 1);
                  active = 0;
               end else begin
                  check("run_busy", longint'(bus.busy), 1);
                  if (wc > TMO) begin
                     n_tests++;
                     n_fail++;
                     $display("FAIL model_timeout: no done after %0d cycles, expected one", wc);
                     active = 0;
                  end
               end
            end else begin
               check("idle_done", longint'(bus.done), 0);
               check("idle_busy", longint'(bus.busy), 0);
               check("idle_out", longint'(bus.out), longint'(held_out));
               check("idle_error", longint'(bus.error), longint'(held_err));
`ifdef RELPRIME_CYCLE_COUNT_EN
               check("idle_cycles", longint'(bus.cycles), held_cyc);
`endif
            end
         end
      end
   end

   // Inputs change 1 time unit after a rising edge
   task automatic pulse(input int n);
      bus.start = 1'b1;
      bus.n_in  = W'(n);
      @(posedge CLK);
      #1;
      bus.start = 1'b0;
      bus.n_in  = W'($urandom);
   endtask

   task automatic wait_done(input bit noise, output int k);
      k = 0;
      do begin
         @(negedge CLK);
         k++;
         if (noise && !bus.done) begin
            #1;
            bus.start = 1'($urandom_range(0, 1));
            bus.n_in  = W'($urandom);
         end
      end while (!bus.done && k < TMO);
      bus.start = 1'b0;
      if (!bus.done) begin
         n_tests++;
         n_fail++;
         $display("FAIL wait_done: no done within %0d cycles, expected done=1", k);
      end
   endtask

   task automatic run(input int n, input int exp_o, input int exp_e, input bit noise,
                      output int k);
      pulse(n);
      wait_done(noise, k);
      check("run_out", longint'(bus.out), longint'(exp_o));
      check("run_error", longint'(bus.error), longint'(exp_e));
      check("run_busy_low", longint'(bus.busy), 0);
      @(posedge CLK);
      #1;
   endtask

   initial begin
      int k;
      int n;
      reset     = 1'b1;
      bus.start = 1'b0;
      bus.n_in  = '0;
      repeat (3) @(posedge CLK);
      #1;
      reset = 1'b0;

      // Pin the model with hand-computed answers
      check("model_6", longint'(model_relprime(6)), 5);
      check("model_30", longint'(model_relprime(30)), 7);
      check("model_5040", longint'(model_relprime(5040)), 11);
      check("model_65535", longint'(model_relprime(65535)), 2);

      run(1, 2, 0, 1'b0, k);
`ifdef RELPRIME_CYCLE_COUNT_EN
      check("cycles_n1", longint'(bus.cycles), longint'(k + 1));
      repeat (3) @(posedge CLK);
      #1;
      check("cycles_hold", longint'(bus.cycles), longint'(k + 1));
`endif
      run(6, 5, 0, 1'b0, k);
      run(30, 7, 0, 1'b0, k);
      run(5040, 11, 0, 1'b0, k);
      run(0, 0, 1, 1'b0, k);
      check("zero_latency_ok", longint'(k <= 2), 1);
      run(5, 2, 0, 1'b0, k);
      run(65535, 2, 0, 1'b0, k);
      run(2, 3, 0, 1'b0, k);

      // Re-start while busy must be ignored
      pulse(30);
      repeat (3) @(posedge CLK);
      #1;
      pulse(9);
      wait_done(1'b0, k);
      check("restart_ignored_out", longint'(bus.out), 7);
      @(posedge CLK);
      #1;

      // Reset mid-run aborts cleanly
      pulse(6);
      repeat (4) @(posedge CLK);
      #1;
      reset = 1'b1;
      @(posedge CLK);
      @(negedge CLK);
      check("midrst_busy", longint'(bus.busy), 0);
      check("midrst_out", longint'(bus.out), 0);
      @(posedge CLK);
      #1;
      reset = 1'b0;
      run(6, 5, 0, 1'b0, k);

      // Random operands, with start noise while busy
      repeat (25) begin
         n = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 3))
                                         : int'($urandom_range(1, 400));
         run(n, model_relprime(n), (n == 0) ? 1 : 0, 1'($urandom_range(0, 1)), k);
      end

      repeat (3) @(posedge CLK);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #5000000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/relprime_engine.md
Name: relprime_engine

Overview:
- Hardware coprocessor for the relprime computation: given n, returns the smallest m >= 2 with gcd(n, m) == 1.
- Sits downstream of the processor register file. It takes the operand on a start pulse and returns a result word that replaces the software relprime loop in top_level.
- gcd is computed by an iterative subtract-based Euclid sub-module; the outer FSM steps the candidate m.

Parameters:
- WIDTH, 16, data width of n, m and the result.
- CNT_W, 32, width of the optional cycle counter.

Ports:
- CLK  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request pulse; sampled only in IDLE.
- n_in  input  WIDTH  operand n; captured on the accepted start.
- busy  output  1  high while a computation is in progress.
- done  output  1  one-cycle pulse when out/error become valid.
- out  output  WIDTH  result m; held until the next accepted start.
- error  output  1  set when n == 0 (no coprime exists); held with out.
- cycles  output  CNT_W  present only with RELPRIME_CYCLE_COUNT_EN.

Behaviour:
- Reset values: busy=0, done=0, out=0, error=0, cycles=0; FSM returns to IDLE.
- reset has priority over every other input in every state.
- FSM states: IDLE, LOAD, GCD, DONE.
- IDLE: on start=1, capture n_reg=n_in, set m=2, clear error, go to LOAD.
  - If n_in==0, go straight to DONE with out=0, error=1.
- LOAD: pulse gcd go with (a=n_reg, b=m); go to GCD.
- GCD: wait for gcd_done.
  - If gcd_result==1: out<=m, go to DONE.
  - Otherwise: m<=m+1, go to LOAD.
- DONE: done=1 for exactly this cycle, busy=0; return to IDLE.
- busy=1 in LOAD and GCD. The cycle after an accepted start, busy is already 1.
- A start arriving while busy or in DONE is ignored (no queueing). A start in IDLE the cycle after DONE is accepted.
- n_in is don't-care except in the accepting cycle.
- m never overflows: for n >= 1 the answer is <= n+1. For n = 2^WIDTH-1 (odd) the answer is 2. No wrap logic is needed; an assertion flags m wrapping to 0.
- gcd sub-module:
  - On go, load a, b.
  - Each following cycle with a != b: if a > b then a <= a-b, else b <= b-a.
  - gcd_done=1 (registered) the cycle after a==b is first observed; result=a.
  - Inputs are always nonzero.
  - Latency is at most max(a,b) cycles.
- Reset mid-computation aborts cleanly. The next start after reset behaves identically to a first start.

Optional Feature:
- Macro: RELPRIME_CYCLE_COUNT_EN.
- With the macro: cycles counts clock cycles from the accepted start up to and including DONE.
  - Saturates at 2^CNT_W-1.
  - Updates with done; holds until the next accepted start.
  - Clears on reset.
- Without the macro: the cycles port and the counter do not exist; the rest of the behaviour is identical.

Decomposition:
- Package relprime_pkg holds:
  - state enum type (IDLE, LOAD, GCD, DONE);
  - default WIDTH constant;
  - constant M_INIT = 2.
- Single sub-module gcd_sub: go/done handshake, a/b/result ports, parameter WIDTH.
- The outer FSM and the m counter live in relprime_engine.

Test Plan:
- n_in=1, start pulsed one cycle -> a single done pulse; out=2, error=0; busy falls in the same cycle done rises.
- Back-to-back runs n_in=6, then 30, then 5040 (each new start in the IDLE cycle after done) -> out=5, then 7, then 11; error=0 each time.
- n_in=0 -> done within 2 cycles of start, out=0, error=1. A following run with n_in=5 -> out=2, error cleared.
- n_in=65535 -> out=2. Then n_in=2 -> out=3.
- Start re-pulsed with n_in=9 while busy on n_in=30 -> ignored; out=7 and exactly one done pulse. reset asserted mid-run -> busy=0, out=0 next cycle; a new run with n_in=6 -> out=5.
- With RELPRIME_CYCLE_COUNT_EN, n_in=1 -> cycles equals the measured start-to-done distance inclusive and is stable until the next start. Without the macro, the design compiles with no cycles port.
